mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single DPI-backed memory port between the instruction-fetch (IFU) and load/store
//   (LSU) requesters. One transaction is outstanding at a time, with valid/ready handshakes on
//   every interface. LSU has fixed priority, bounded by an IFU anti-starvation counter.
//   Adds a response timeout and rejects illegal MemOp codes before they reach memory.
// PARAMETERS
//   STARVE_MAX  4    consecutive LSU grants, with IFU pending, after which IFU wins once (1..15)
//   TIMEOUT     255  max cycles in WAIT before an error response is forced (1..255)
// PORTS
//   clk            in   1   clock, rising edge
//   rst            in   1   reset, asynchronous, active-high
//   ifu_req_valid  in   1   IFU fetch request
//   ifu_req_ready  out  1   IFU request accepted this cycle
//   ifu_addr       in   32  fetch address
//   ifu_rsp_valid  out  1   one-cycle pulse: IFU response
//   ifu_rsp_data   out  32  instruction word
//   ifu_rsp_err    out  1   timeout on IFU transaction
//   lsu_req_valid  in   1   LSU request
//   lsu_req_ready  out  1   LSU request accepted this cycle
//   lsu_addr       in   32  data address
//   lsu_wen        in   1   1=store, 0=load
//   lsu_wdata      in   32  store data (rs2)
//   lsu_memop      in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//   lsu_rsp_valid  out  1   one-cycle pulse: LSU response (also for stores)
//   lsu_rsp_data   out  32  raw load word from memory (extension done downstream); 0 for stores
//   lsu_rsp_err    out  1   illegal MemOp or timeout
//   mem_req_valid  out  1   request to memory port
//   mem_req_ready  in   1   memory accepts request
//   mem_addr/mem_wdata out 32 each; mem_wen out 1; mem_memop out 3   registered request fields
//   mem_rsp_valid  in   1   memory response
//   mem_rsp_data   in   32  memory read data
//   busy           out  1   state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE. All outputs 0, streak=0, timeout counter=0. An in-flight transaction is
//     dropped; no response is issued for it.
//   FSM: IDLE -> ISSUE -> WAIT -> IDLE, plus IDLE -> REJECT -> IDLE.
//   IDLE arbitration (combinational *_req_ready, asserted only in IDLE):
//     - lsu wins if lsu_req_valid && !(ifu_req_valid && streak==STARVE_MAX); otherwise ifu wins
//       if ifu_req_valid.
//     - At most one of ifu_req_ready and lsu_req_ready is high.
//     - Winner: addr, wen, wdata and memop are latched; owner is recorded. IFU uses wen=0,
//       memop=010.
//   streak: +1 on an LSU grant while ifu_req_valid=1; cleared on an IFU grant or on an LSU
//     grant with ifu_req_valid=0; saturates at STARVE_MAX.
//   Legal LSU MemOp:
//     - load: {000,001,010,100,101}; store: {000,001,010}.
//     - Illegal -> REJECT: no mem_req_valid. Next cycle, lsu_rsp_valid=1, lsu_rsp_err=1,
//       lsu_rsp_data=32'hdeafbeaf; then IDLE.
//   ISSUE: mem_req_valid=1 with stable fields until mem_req_ready=1, then WAIT. mem_req_valid
//     drops the cycle after the handshake.
//   WAIT: counter increments each cycle.
//     - On mem_rsp_valid: the owner's rsp_valid pulses next cycle, with data=mem_rsp_data
//       (0 if store) and err=0; state becomes IDLE in that same cycle.
//     - If the counter reaches TIMEOUT first: owner rsp_valid=1, err=1, data=32'hdeafbeaf;
//       state becomes IDLE.
//   mem_rsp_valid outside WAIT is ignored (late or stale responses are discarded).
//   A new grant may occur in the cycle where rsp_valid is high (back-to-back).
//   Minimum latency: accept at T, mem_req_valid at T+1; with ready and rsp at T+1,
//     rsp_valid at T+2.
//   rsp_valid/err/data are registered and held only for the pulse cycle; data returns to 0 after.
// TESTING
//   1 IFU only, addr 0x80000000, mem ready=1, rsp next cycle with 0x00100093
//     -> ifu_rsp_valid at T+2, data 0x00100093, err=0.
//   2 IFU+LSU both valid every cycle, STARVE_MAX=4 -> grant order L,L,L,L,I,L,L,L,L,I.
//   3 LSU store memop=010, addr 0x80001000, wdata 0x12345678 -> mem_wen=1 with those fields;
//     lsu_rsp_valid pulses with data 0.
//   4 LSU store memop=101 -> no mem_req_valid; next cycle lsu_rsp_err=1, data 0xdeafbeaf.
//   5 TIMEOUT=8, memory never responds -> rsp err=1 exactly 8 cycles after entering WAIT;
//     later mem_rsp_valid is ignored.
//   6 rst pulsed in WAIT -> all outputs 0 asynchronously, busy=0; no owner response;
//     the next request is serviced normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IFU and LSU, one transaction in flight.
// LSU has priority bounded by an IFU anti-starvation streak; adds response timeout and MemOp checks.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_rsp_valid,
    output logic [31:0] ifu_rsp_data,
    output logic        ifu_rsp_err,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [2:0]  lsu_memop,
    output logic        lsu_rsp_valid,
    output logic [31:0] lsu_rsp_data,
    output logic        lsu_rsp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    output logic [2:0]  mem_memop,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REJECT} state_t;

    localparam logic [31:0] ERR_WORD   = 32'hdeafbeaf;
    localparam logic [3:0]  STREAK_CAP = 4'(STARVE_MAX);
    localparam logic [7:0]  WAIT_LAST  = 8'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [3:0]  streak;
    logic [7:0]  wait_cnt;
    logic        owner_lsu;
    logic        memop_ok, starve, grant_lsu, grant_ifu;
    logic        rsp_hit, timed_out, rsp_fire;
    logic [31:0] rsp_word;

    always_comb begin
        memop_ok  = lsu_wen ? (lsu_memop inside {3'b000, 3'b001, 3'b010})
                            : (lsu_memop inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        starve    = ifu_req_valid && streak == STREAK_CAP;
        grant_lsu = state == IDLE && !rst && lsu_req_valid && !starve;
        grant_ifu = state == IDLE && !rst && ifu_req_valid && !grant_lsu;
        // a response arriving together with the request handshake counts as the reply
        rsp_hit   = mem_rsp_valid && (state == WAIT || (state == ISSUE && mem_req_ready));
        timed_out = state == WAIT && !mem_rsp_valid && wait_cnt == WAIT_LAST;
        rsp_fire  = rsp_hit || timed_out || state == REJECT;
        rsp_word  = !rsp_hit ? ERR_WORD : (mem_wen ? 32'd0 : mem_rsp_data);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = grant_lsu ? (memop_ok ? ISSUE : REJECT) : (grant_ifu ? ISSUE : IDLE);
            ISSUE:   state_nx = mem_req_ready ? (mem_rsp_valid ? IDLE : WAIT) : ISSUE;
            WAIT:    state_nx = (mem_rsp_valid || timed_out) ? IDLE : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        lsu_req_ready = grant_lsu;
        ifu_req_ready = grant_ifu;
        mem_req_valid = state == ISSUE;
        busy          = state != IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak        <= '0;
            wait_cnt      <= '0;
            owner_lsu     <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wen       <= 1'b0;
            mem_memop     <= '0;
            ifu_rsp_valid <= 1'b0;
            ifu_rsp_err   <= 1'b0;
            ifu_rsp_data  <= '0;
            lsu_rsp_valid <= 1'b0;
            lsu_rsp_err   <= 1'b0;
            lsu_rsp_data  <= '0;
        end else begin
            wait_cnt <= state == WAIT ? wait_cnt + 8'd1 : 8'd0;
            if (grant_lsu) begin
                owner_lsu <= 1'b1;
                mem_addr  <= lsu_addr;
                mem_wdata <= lsu_wdata;
                mem_wen   <= lsu_wen;
                mem_memop <= lsu_memop;
                streak    <= !ifu_req_valid ? 4'd0 : (streak == STREAK_CAP ? streak : streak + 4'd1);
            end else if (grant_ifu) begin
                owner_lsu <= 1'b0;
                mem_addr  <= ifu_addr;
                mem_wdata <= '0;
                mem_wen   <= 1'b0;
                mem_memop <= 3'b010;
                streak    <= '0;
            end
            ifu_rsp_valid <= rsp_fire && !owner_lsu;
            ifu_rsp_err   <= rsp_fire && !owner_lsu && !rsp_hit;
            ifu_rsp_data  <= (rsp_fire && !owner_lsu) ? rsp_word : 32'd0;
            lsu_rsp_valid <= rsp_fire && owner_lsu;
            lsu_rsp_err   <= rsp_fire && owner_lsu && !rsp_hit;
            lsu_rsp_data  <= (rsp_fire && owner_lsu) ? rsp_word : 32'd0;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of mem_port_arbiter against a transaction-timeline model.
module tb_mem_port_arbiter;
    localparam int SM = 4;
    localparam int TO = 8;
    localparam logic [31:0] ERRW = 32'hdeafbeaf;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
    logic [31:0] ifu_addr, ifu_rsp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rsp_data;
    logic [2:0]  lsu_memop;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rsp_data;
    logic [2:0]  mem_memop;

    mem_port_arbiter #(.STARVE_MAX(SM), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_memop(lsu_memop),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_memop(mem_memop),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_lat = 0, rsp_lat = 0;
    bit silent = 0, stray = 0;
    bit lat_fixed = 1, fix_silent = 0;
    int fix_rdy = 0, fix_rsp = 0;

    bit act = 0, x_lsu = 0, x_legal = 0, x_err = 0, x_wen = 0;
    int t_grant = 0, t_hs = 0, t_rsp = 0, run = 0;
    logic [31:0] x_addr = 0, x_wdata = 0, x_data = 0;
    logic [2:0]  x_memop = 0;
    bit g_lsu = 0, g_ifu = 0;

    int o_grant = -1, o_hs = -1, o_rsp = -1;
    bit o_mreq_seen = 0, o_rerr = 0;
    logic [31:0] o_addr = 0, o_wdata = 0, o_rdata = 0;
    logic o_wen = 0;
    logic [2:0] o_memop = 0;
    bit glog[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a == 32'h80000000 ? 32'h00100093 : ({a[15:0], ~a[31:16]} ^ 32'h0f0f1234);
    endfunction

    function automatic bit legal(input bit wen, input logic [2:0] op);
        return wen ? (op inside {3'd0, 3'd1, 3'd2}) : (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // memory: ready after rdy_lat cycles of valid, reply rsp_lat cycles after handshake (0 = same cycle)
    initial begin : responder
        int waited, left;
        bit pend;
        logic [31:0] word;
        waited = 0; left = 0; pend = 0; word = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
        forever begin
            @(posedge clk); #2;
            mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
            if (rst) begin
                pend = 0; waited = 0;
            end else begin
                if (pend) begin
                    if (left == 0) begin
                        mem_rsp_valid = 1; mem_rsp_data = word; pend = 0;
                    end else left--;
                end
                if (mem_req_valid) begin
                    if (waited >= rdy_lat) begin
                        mem_req_ready = 1; waited = 0; word = mem_word(mem_addr);
                        if (!silent) begin
                            if (rsp_lat == 0) begin
                                mem_rsp_valid = 1; mem_rsp_data = word;
                            end else begin
                                pend = 1; left = rsp_lat - 1;
                            end
                        end
                    end else waited++;
                end
                if (stray) begin
                    mem_rsp_valid = 1; mem_rsp_data = 32'hbadc0de0;
                end
            end
        end
    end

    task automatic cycle();
        bit idle, e_l, e_i, rv, mv;
        @(negedge clk);
        idle = !act || cyc >= t_rsp;
        e_l  = idle && lsu_req_valid && !(ifu_req_valid && run == SM);
        e_i  = idle && ifu_req_valid && !e_l;
        rv   = act && cyc == t_rsp;
        mv   = act && x_legal && cyc > t_grant && cyc <= t_hs;
        chk("lsu_req_ready", lsu_req_ready, e_l);
        chk("ifu_req_ready", ifu_req_ready, e_i);
        chk("busy", busy, act && cyc > t_grant && cyc < t_rsp);
        chk("mem_req_valid", mem_req_valid, mv);
        if (mv) begin
            chk("mem_addr", mem_addr, x_addr);
            chk("mem_wdata", mem_wdata, x_wdata);
            chk("mem_wen", mem_wen, x_wen);
            chk("mem_memop", mem_memop, x_memop);
        end
        chk("ifu_rsp_valid", ifu_rsp_valid, rv && !x_lsu);
        chk("ifu_rsp_err", ifu_rsp_err, rv && !x_lsu && x_err);
        chk("ifu_rsp_data", ifu_rsp_data, (rv && !x_lsu) ? x_data : 32'd0);
        chk("lsu_rsp_valid", lsu_rsp_valid, rv && x_lsu);
        chk("lsu_rsp_err", lsu_rsp_err, rv && x_lsu && x_err);
        chk("lsu_rsp_data", lsu_rsp_data, (rv && x_lsu) ? x_data : 32'd0);
        if (mem_req_valid) o_mreq_seen = 1;
        if (mem_req_valid && mem_req_ready) begin
            o_hs = cyc; o_addr = mem_addr; o_wdata = mem_wdata; o_wen = mem_wen; o_memop = mem_memop;
        end
        if (ifu_rsp_valid || lsu_rsp_valid) begin
            o_rsp = cyc;
            o_rdata = ifu_rsp_valid ? ifu_rsp_data : lsu_rsp_data;
            o_rerr = ifu_rsp_valid ? ifu_rsp_err : lsu_rsp_err;
        end
        if (lsu_req_ready || ifu_req_ready) begin
            o_grant = cyc;
            glog.push_back(ifu_req_ready);
        end
        if (rv) act = 0;
        g_lsu = e_l; g_ifu = e_i;
        if (e_l) run = ifu_req_valid ? (run < SM ? run + 1 : SM) : 0;
        else if (e_i) run = 0;
        if (e_l || e_i) begin
            act = 1; t_grant = cyc; x_lsu = e_l;
            x_addr  = e_l ? lsu_addr : ifu_addr;
            x_wen   = e_l && lsu_wen;
            x_wdata = e_l ? lsu_wdata : 32'd0;
            x_memop = e_l ? lsu_memop : 3'b010;
            x_legal = !e_l || legal(lsu_wen, lsu_memop);
            rdy_lat = lat_fixed ? fix_rdy : $urandom_range(0, 2);
            rsp_lat = lat_fixed ? fix_rsp : $urandom_range(0, TO);
            silent  = lat_fixed ? fix_silent : ($urandom_range(0, 7) == 0);
            if (!x_legal) begin
                t_rsp = cyc + 2; x_err = 1; x_data = ERRW;
            end else begin
                t_hs   = cyc + 1 + rdy_lat;
                x_err  = silent;
                t_rsp  = silent ? t_hs + TO + 1 : t_hs + rsp_lat + 1;
                x_data = silent ? ERRW : (x_wen ? 32'd0 : mem_word(x_addr));
            end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (act || busy); i++) cycle();
        chk("drain_busy", busy, 0);
    endtask

    task automatic clear_obs();
        o_grant = -1; o_hs = -1; o_rsp = -1; o_mreq_seen = 0; o_rerr = 0; o_rdata = 0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit exp_order[10];
        exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        rst = 1;
        ifu_req_valid = 1; ifu_addr = 0;
        lsu_req_valid = 1; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_memop = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ifu_ready", ifu_req_ready, 0);
        chk("rst_lsu_ready", lsu_req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_ctl", {mem_wen, mem_memop}, 0);
        chk("rst_ifu_rsp", {ifu_rsp_valid, ifu_rsp_err}, 0);
        chk("rst_ifu_rsp_data", ifu_rsp_data, 0);
        chk("rst_lsu_rsp", {lsu_rsp_valid, lsu_rsp_err}, 0);
        chk("rst_lsu_rsp_data", lsu_rsp_data, 0);
        ifu_req_valid = 0; lsu_req_valid = 0;
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        // 1: IFU fetch, memory ready and replying in the handshake cycle
        clear_obs();
        ifu_req_valid = 1; ifu_addr = 32'h80000000;
        cycle();
        ifu_req_valid = 0;
        drain();
        chk("t1_latency", o_rsp - o_grant, 2);
        chk("t1_data", o_rdata, 32'h00100093);
        chk("t1_err", o_rerr, 0);

        // 2: both requesters always valid
        glog.delete();
        ifu_req_valid = 1; ifu_addr = 32'h80000004;
        lsu_req_valid = 1; lsu_addr = 32'h80002000; lsu_wen = 0; lsu_memop = 3'b010;
        for (int i = 0; i < 200 && glog.size() < 10; i++) cycle();
        ifu_req_valid = 0; lsu_req_valid = 0;
        for (int i = 0; i < 10; i++)
            chk($sformatf("t2_grant%0d_is_ifu", i), glog.size() > i ? int'(glog[i]) : 2, exp_order[i]);
        drain();

        // 3: legal word store with one cycle of backpressure
        clear_obs();
        fix_rdy = 1;
        lsu_req_valid = 1; lsu_wen = 1; lsu_memop = 3'b010; lsu_addr = 32'h80001000; lsu_wdata = 32'h12345678;
        cycle();
        lsu_req_valid = 0;
        drain();
        fix_rdy = 0;
        chk("t3_addr", o_addr, 32'h80001000);
        chk("t3_wdata", o_wdata, 32'h12345678);
        chk("t3_wen", o_wen, 1);
        chk("t3_memop", o_memop, 3'b010);
        chk("t3_rsp_seen", o_rsp >= 0, 1);
        chk("t3_data", o_rdata, 0);

        // 4: illegal store memop
        clear_obs();
        lsu_req_valid = 1; lsu_wen = 1; lsu_memop = 3'b101; lsu_addr = 32'h80001004;
        cycle();
        lsu_req_valid = 0;
        drain();
        chk("t4_no_mem_req", o_mreq_seen, 0);
        chk("t4_latency", o_rsp - o_grant, 2);
        chk("t4_err", o_rerr, 1);
        chk("t4_data", o_rdata, ERRW);

        // 5: silent memory, then a stray response while idle
        clear_obs();
        fix_silent = 1;
        ifu_req_valid = 1; ifu_addr = 32'h80000100;
        cycle();
        ifu_req_valid = 0;
        drain();
        chk("t5_timeout_cycles", o_rsp - o_hs, TO + 1);
        chk("t5_err", o_rerr, 1);
        chk("t5_data", o_rdata, ERRW);
        o_rsp = -1;
        stray = 1;
        cycle();
        stray = 0;
        repeat (3) cycle();
        chk("t5_stray_ignored", o_rsp, -1);

        // 6: reset while waiting on memory
        ifu_req_valid = 1; ifu_addr = 32'h80000200;
        cycle();
        ifu_req_valid = 0;
        cycle();
        chk("t6_busy_pre", busy, 1);
        rst = 1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_mem_req_valid", mem_req_valid, 0);
        chk("t6_mem_addr", mem_addr, 0);
        chk("t6_rsp", {ifu_rsp_valid, ifu_rsp_err, lsu_rsp_valid, lsu_rsp_err}, 0);
        act = 0; run = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        fix_silent = 0;
        clear_obs();
        repeat (TO + 3) cycle();
        chk("t6_no_owner_rsp", o_rsp, -1);
        lsu_req_valid = 1; lsu_wen = 0; lsu_memop = 3'b000; lsu_addr = 32'h80003000;
        cycle();
        lsu_req_valid = 0;
        drain();
        chk("t6_next_data", o_rdata, mem_word(32'h80003000));
        chk("t6_next_err", o_rerr, 0);

        // 7: random traffic, random memory timing
        lat_fixed = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!ifu_req_valid && $urandom_range(0, 1) == 0) begin
                ifu_req_valid = 1; ifu_addr = $urandom & 32'hfffffffc;
            end
            if (!lsu_req_valid && $urandom_range(0, 1) == 0) begin
                lsu_req_valid = 1; lsu_addr = $urandom; lsu_wdata = $urandom;
                lsu_wen = 1'($urandom_range(0, 1)); lsu_memop = 3'($urandom_range(0, 7));
            end
            cycle();
            if (g_ifu) ifu_req_valid = 0;
            if (g_lsu) lsu_req_valid = 0;
        end
        ifu_req_valid = 0; lsu_req_valid = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
